// File: rtl/alu_seq_arbiter.sv
// Two-requester round-robin front end for a nibble-serial sequential ALU.
// A granted request is replayed to the ALU as reset, op1, op2, opcode. The block
// then waits for done, with a timeout, and returns the captured result to the
// requester that owns the transaction.
module alu_seq_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] a_op1,
  input  logic [3:0] a_op2,
  input  logic [3:0] a_opc,
  input  logic [3:0] b_op1,
  input  logic [3:0] b_op2,
  input  logic [3:0] b_opc,
  output logic [1:0] resp_valid,
  output logic [3:0] resp_result,
  output logic [2:0] resp_flags,
  output logic       resp_err,
  output logic       alu_rst,
  output logic [3:0] alu_data,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags
);

  typedef enum logic [2:0] {
    StIdle, StSync, StSendOp1, StSendOp2, StSendOpc, StWaitDone, StResp
  } state_e;

  // Last WAIT_DONE count value before the timeout fires.
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;    // 0 = A granted last, 1 = B granted last
  logic       owner_q, owner_d;  // 0 = A, 1 = B
  logic [3:0] op1_q, op1_d;
  logic [3:0] op2_q, op2_d;
  logic [3:0] opc_q, opc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic [2:0] flags_q, flags_d;
  logic       err_q, err_d;
  logic [1:0] grant;

  // Round-robin winner, offered only in IDLE and never while in reset.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle && !reset) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Next-state logic: request capture, ALU sequencing, done or timeout handling.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          last_d  = grant[1];
          op1_d   = grant[1] ? b_op1 : a_op1;
          op2_d   = grant[1] ? b_op2 : a_op2;
          opc_d   = grant[1] ? b_opc : a_opc;
          state_d = StSync;
        end
      end
      StSync:    state_d = StSendOp1;
      StSendOp1: state_d = StSendOp2;
      StSendOp2: state_d = StSendOpc;
      StSendOpc: begin
        cnt_d   = 4'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (alu_flags[0]) begin
          result_d = alu_result;
          flags_d  = alu_flags[3:1];
          err_d    = 1'b0;
          state_d  = StResp;
        end else if (cnt_q == TimeoutLast) begin
          result_d = 4'd0;
          flags_d  = 3'd0;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op1_q    <= 4'd0;
      op2_q    <= 4'd0;
      opc_q    <= 4'd0;
      cnt_q    <= 4'd0;
      result_q <= 4'd0;
      flags_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state; reset masks them so they are quiet immediately.
  always_comb begin
    req_ready  = grant;
    resp_valid = 2'b00;
    alu_data   = 4'd0;
    alu_rst    = reset || (state_q == StSync);
    if (!reset) begin
      unique case (state_q)
        StSendOp1: alu_data = op1_q;
        StSendOp2: alu_data = op2_q;
        StSendOpc: alu_data = opc_q;
        StResp:    resp_valid = owner_q ? 2'b10 : 2'b01;
        default:   alu_data = 4'd0;
      endcase
    end
  end

  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Directed bench for alu_seq_arbiter with a behavioural nibble-serial ALU.
module tb_alu_seq_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_ready, resp_valid;
  logic [3:0] a_op1, a_op2, a_opc, b_op1, b_op2, b_opc;
  logic [3:0] resp_result, alu_data, alu_result, alu_flags;
  logic [2:0] resp_flags;
  logic       resp_err, alu_rst;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .a_op1(a_op1), .a_op2(a_op2), .a_opc(a_opc),
    .b_op1(b_op1), .b_op2(b_op2), .b_opc(b_opc),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
    .resp_err(resp_err), .alu_rst(alu_rst), .alu_data(alu_data),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // ALU model: takes op1, op2, opc on successive edges after alu_rst; done is
  // sticky until alu_rst. opc 0 = add {sign,0,carry}; opc 1 = and {sign,zero,0}.
  logic [1:0] m_idx = 2'd0;
  logic [3:0] m_a = 4'd0, m_b = 4'd0, m_cnt = 4'd0;
  logic [6:0] m_out = 7'd0;
  logic       m_done = 1'b0, m_pend = 1'b0;
  bit         m_never = 1'b0;
  int         m_delay = 0;

  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] opc);
    logic [4:0] s;
    logic [3:0] r;
    if (opc == 4'd0) begin
      s = {1'b0, a} + {1'b0, b};
      return {s[3], 1'b0, s[4], s[3:0]};
    end else if (opc == 4'd1) begin
      r = a & b;
      return {r[3], (r == 4'd0), 1'b0, r};
    end
    return 7'd0;
  endfunction

  always @(posedge clk) begin
    if (alu_rst) begin
      m_idx  <= 2'd0;
      m_done <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      if (m_idx == 2'd0) m_a <= alu_data;
      if (m_idx == 2'd1) m_b <= alu_data;
      if (m_idx == 2'd2) begin
        m_out <= alu_fn(m_a, m_b, alu_data);
        if (!m_never) begin
          if (m_delay == 0) m_done <= 1'b1;
          else begin
            m_pend <= 1'b1;
            m_cnt  <= 4'(m_delay);
          end
        end
      end
      if (m_idx != 2'd3) m_idx <= m_idx + 2'd1;
      if (m_pend) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd1) begin
          m_done <= 1'b1;
          m_pend <= 1'b0;
        end
      end
    end
  end

  assign alu_result = m_out[3:0];
  assign alu_flags  = {m_out[6:4], m_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester, checking grant, ALU
  // sequence, latency and the captured response.
  task automatic run_txn(input bit who, input logic [3:0] o1, input logic [3:0] o2,
                         input logic [3:0] oc, input int exp_lat, input logic [3:0] er,
                         input logic [2:0] ef, input logic ee, input string tag);
    int         cyc;
    logic [3:0] seq [3];
    logic       rst_seen, stale;
    if (!who) begin
      a_op1 = o1; a_op2 = o2; a_opc = oc; req_valid = 2'b01;
    end else begin
      b_op1 = o1; b_op2 = o2; b_opc = oc; req_valid = 2'b10;
    end
    #1;
    check({tag, "_grant"}, 32'(req_ready), who ? 32'd2 : 32'd1);
    tick();
    req_valid = 2'b00;
    // Scramble operands so only the latched copy can reach the ALU.
    a_op1 = ~o1; a_op2 = ~o2; a_opc = ~oc;
    b_op1 = ~o1; b_op2 = ~o2; b_opc = ~oc;
    cyc = 1;
    rst_seen = alu_rst;
    stale = 1'b0;
    seq[0] = 4'hx; seq[1] = 4'hx; seq[2] = 4'hx;
    while (resp_valid == 2'b00 && cyc < 40) begin
      if (cyc >= 2 && cyc <= 4) begin
        seq[cyc-2] = alu_data;
        stale |= alu_flags[0];
      end
      tick();
      cyc++;
    end
    check({tag, "_sync_rst"}, 32'(rst_seen), 32'd1);
    check({tag, "_op1"}, 32'(seq[0]), 32'(o1));
    check({tag, "_op2"}, 32'(seq[1]), 32'(o2));
    check({tag, "_opc"}, 32'(seq[2]), 32'(oc));
    check({tag, "_no_stale_done"}, 32'(stale), 32'd0);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_resp_valid"}, 32'(resp_valid), who ? 32'd2 : 32'd1);
    check({tag, "_result"}, 32'(resp_result), 32'(er));
    check({tag, "_flags"}, 32'(resp_flags), 32'(ef));
    check({tag, "_err"}, 32'(resp_err), 32'(ee));
    tick();
    check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, "_hold"}, 32'(resp_result), 32'(er));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_alu_rst", 32'(alu_rst), 32'd1);
    check("rst_alu_data", 32'(alu_data), 32'd0);
    check("rst_result", 32'(resp_result), 32'd0);
    check("rst_flags", 32'(resp_flags), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    req_valid = 2'b00;
    tick();
    check("post_rst_alu_rst", 32'(alu_rst), 32'd0);
  endtask

  initial begin
    int pulses;
    int cyc;
    a_op1 = 4'd0; a_op2 = 4'd0; a_opc = 4'd0;
    b_op1 = 4'd0; b_op2 = 4'd0; b_opc = 4'd0;
    do_reset();

    run_txn(1'b0, 4'd3, 4'd4, 4'd0, 6, 4'd7, 3'b000, 1'b0, "basic_a");
    run_txn(1'b1, 4'hF, 4'd1, 4'd0, 6, 4'd0, 3'b001, 1'b0, "carry_b");
    run_txn(1'b0, 4'd5, 4'hA, 4'd1, 6, 4'd0, 3'b010, 1'b0, "zero_a");
    run_txn(1'b1, 4'd9, 4'd2, 4'd0, 6, 4'hB, 3'b100, 1'b0, "sign_b");
    // Done is still high from the previous transaction here.
    run_txn(1'b0, 4'd1, 4'd1, 4'd0, 6, 4'd2, 3'b000, 1'b0, "stale_a");

    m_never = 1'b1;
    run_txn(1'b1, 4'd1, 4'd2, 4'd0, 13, 4'd0, 3'b000, 1'b1, "timeout_b");
    m_never = 1'b0;
    // Done arrives in the eighth WAIT_DONE cycle, the same cycle as the timeout.
    m_delay = 7;
    run_txn(1'b0, 4'd6, 4'd1, 4'd0, 13, 4'd7, 3'b000, 1'b0, "late_done_a");
    m_delay = 0;

    // Reset during SEND_OP2.
    a_op1 = 4'd2; a_op2 = 4'd5; a_opc = 4'd0;
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("mid_op2_data", 32'(alu_data), 32'd5);
    reset = 1'b1;
    #1;
    check("mid_alu_rst", 32'(alu_rst), 32'd1);
    check("mid_alu_data", 32'(alu_data), 32'd0);
    tick();
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_result", 32'(resp_result), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (resp_valid != 2'b00) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);
    run_txn(1'b1, 4'd2, 4'd3, 4'd0, 6, 4'd5, 3'b000, 1'b0, "after_rst_b");

    // Round robin with both requesters held valid from reset.
    do_reset();
    a_op1 = 4'd1; a_op2 = 4'd1; a_opc = 4'd0;
    b_op1 = 4'd2; b_op2 = 4'd2; b_opc = 4'd0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (req_ready == 2'b00 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("rr_grant", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      cyc = 0;
      while (resp_valid == 2'b00 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("rr_resp", 32'(resp_valid), (k % 2 == 1) ? 32'd2 : 32'd1);
      check("rr_result", 32'(resp_result), (k % 2 == 1) ? 32'd4 : 32'd2);
    end
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, max cycles spent in WAIT_DONE before abort; legal range 2-15.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  2  request pending; bit 0 = requester A, bit 1 = requester B.
REQ-005 req_ready  out  2  grant/accept strobe, at most one bit high.
REQ-006 a_op1, a_op2, a_opc  in  4 each  requester A operand 1, operand 2 and opcode.
REQ-007 b_op1, b_op2, b_opc  in  4 each  requester B operand 1, operand 2 and opcode.
REQ-008 resp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-009 resp_result  out  4  captured ALU result.
REQ-010 resp_flags  out  3  captured {sign, zero, carry}.
REQ-011 resp_err  out  1  transaction aborted by timeout.
REQ-012 alu_rst  out  1  drives the sequential ALU reset.
REQ-013 alu_data  out  4  drives the ALU nibble input.
REQ-014 alu_result  in  4  ALU result nibble.
REQ-015 alu_flags  in  4  ALU {sign, zero, carry, done}.

Function
REQ-016 FSM states SHALL be IDLE, SYNC, SEND_OP1, SEND_OP2, SEND_OPC, WAIT_DONE, RESP.
REQ-017 In IDLE, req_ready SHALL be driven combinationally to the round-robin winner among asserted req_valid bits; it SHALL be 0 in all other states.
REQ-018 Round-robin: with one requester valid, it wins; with both valid, the requester not granted last wins; last-grant SHALL reset to B, so A wins first.
REQ-019 On a handshake edge (req_valid & req_ready), the block SHALL latch owner, op1, op2 and opc, and SHALL move to SYNC.
REQ-020 SYNC SHALL last 1 cycle with alu_rst=1, clearing the ALU's sticky done flag and realigning its operand state.
REQ-021 SEND_OP1, SEND_OP2 and SEND_OPC SHALL each last 1 cycle, driving alu_data = latched op1, op2 and opc respectively, with alu_rst=0.
REQ-022 In all other states, alu_data SHALL be 0.
REQ-023 WAIT_DONE SHALL sample alu_flags[0] each edge. If it is 1, the block SHALL capture alu_result into resp_result, alu_flags[3:1] into resp_flags, and resp_err=0, then move to RESP.
REQ-024 WAIT_DONE SHALL count cycles with a 4-bit counter cleared on entry. If done has not been seen by the TIMEOUT-th cycle, the block SHALL set resp_result=0, resp_flags=0, resp_err=1, and move to RESP.
REQ-025 Done and timeout in the same cycle: done SHALL win.
REQ-026 RESP SHALL last 1 cycle with resp_valid[owner]=1, then return to IDLE.
REQ-027 resp_result, resp_flags and resp_err SHALL hold until the next capture.
REQ-028 Minimum latency, handshake edge to resp_valid: 6 cycles (SYNC, 3 SEND, 1 WAIT, RESP).
REQ-029 Request inputs SHALL be ignored outside IDLE, so a requester cannot pre-empt a transaction in flight.
REQ-030 A requester deasserting req_valid before its grant SHALL lose the request with no side effects.
REQ-031 Operands SHALL be passed unmodified; the block performs no arithmetic.

Reset
REQ-032 While reset=1, the block SHALL set state=IDLE, last-grant=B, counter=0, req_ready=0, resp_valid=0, resp_result=0, resp_flags=0, resp_err=0, alu_data=0.
REQ-033 alu_rst SHALL be 1 while reset=1 and in SYNC, and 0 otherwise.
REQ-034 Reset mid-transaction SHALL abort the transaction with no resp_valid pulse; the next request SHALL restart from SYNC.

Verification (bench uses an ALU model asserting done 1 cycle after the opcode nibble, sticky until alu_rst)
REQ-035 A requests op1=3, op2=4, opc=0 -> alu_data sequence 3, 4, 0 after one alu_rst cycle; resp_valid=2'b01 six cycles after handshake; resp_result=7, resp_flags=3'b000, resp_err=0.
REQ-036 A and B valid on the same cycle, held valid -> grants in order A, B, A, B; no overlap of resp_valid pulses.
REQ-037 ALU model never asserts done, TIMEOUT=8 -> resp_valid pulse after 8 WAIT_DONE cycles with resp_err=1 and resp_result=0.
REQ-038 Stale done: done left high from a previous transaction -> SYNC clears it; the new result is captured only after SEND_OPC, never during the SEND states.
REQ-039 reset asserted during SEND_OP2 -> all outputs reach reset values on the next edge, no resp_valid pulse; a following B request completes normally.
REQ-040 op1=F, op2=1, opc=0 with the model returning carry -> resp_result=0, resp_flags=3'b001.
